evolved_circuit_tester: RTL and testbench
=========================================

Name: evolved_circuit_tester

Overview:
- Stimulus/response end for the combinational evolved circuits under test.
- Drives every input vector (0 .. 2^IN_WIDTH-1) onto the circuit under test (CUT), waits a settle window, then samples the CUT output repeatedly.
- Reports per-vector statistics over a valid/ready stream and accumulates a truth table.
- Sits between the CUT and the host/readback logic on the test board.

Parameters:
- IN_WIDTH, 5, CUT input width; sweep covers 2^IN_WIDTH vectors.
- SETTLE_CYCLES, 4, cycles held after each vector change before sampling. Must be >= 3, because the synchronizer consumes 2.
- SAMPLES, 16, output samples taken per vector. Must be >= 1.
- ONES_W, $clog2(SAMPLES+1), width of the ones count (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, single domain.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- cut_in  output  IN_WIDTH  registered stimulus to the CUT.
- cut_out  input  1  CUT output, asynchronous to clk.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- res_valid  output  1  per-vector result available.
- res_ready  input  1  consumer accepts the result.
- res_vector  output  IN_WIDTH  vector the result belongs to.
- res_ones  output  ONES_W  number of samples equal to 1.
- res_stable  output  1  all samples identical (res_ones == 0 or res_ones == SAMPLES).
- truth_table  output  2^IN_WIDTH  bit v = majority value for vector v.

Behaviour:
- Reset (async assert, synchronous deassert handled upstream):
  - cut_in=0, busy=0, done=0, res_valid=0, res_vector=0, res_ones=0, res_stable=0, truth_table=0.
  - Synchronizer flops=0, state=IDLE.
- cut_out passes through a 2-flop synchronizer. Only the synchronized bit is used.
- FSM states: IDLE, SETTLE, SAMPLE, REPORT.
- IDLE:
  - start=1 → vec=0, cut_in=0, truth_table=0, done=0, busy=1, settle counter=0, go to SETTLE.
  - start is ignored in every state other than IDLE.
- SETTLE:
  - Occupies exactly SETTLE_CYCLES cycles.
  - Then clear the ones counter, capture the first sample reference, go to SAMPLE.
- SAMPLE:
  - Occupies exactly SAMPLES cycles. Each cycle adds the synchronized bit to the ones counter.
  - Counter saturation is impossible by construction of ONES_W.
  - Then latch res_vector=vec, res_ones, res_stable; set res_valid=1; go to REPORT.
- REPORT:
  - res_valid and all res_* fields are held stable while res_ready=0. cut_in is also held.
  - On res_valid & res_ready: res_valid=0 and truth_table[vec] = (res_ones > SAMPLES/2), integer divide. A tie resolves to 0.
  - If vec == 2^IN_WIDTH-1: busy=0, done=1, go to IDLE.
  - Otherwise vec+1 and cut_in=vec+1 on the same edge, settle counter=0, go to SETTLE.
- Timing:
  - Per-vector period with res_ready held high = SETTLE_CYCLES + SAMPLES + 1 cycles.
  - done rises on the edge completing the final handshake.
- Wrap: vec never wraps. The sweep ends at the last vector.
- Reset mid-sweep: all outputs return to reset values immediately. The next start restarts from vector 0.
- res_ready high outside REPORT has no effect.

Decomposition:
- Shared package evolved_tester_pkg: FSM state enum, and a function computing ONES_W from SAMPLES.
- One sub-module: bit_sync_2ff, the 2-flop synchronizer with async active-low reset.
- The FSM, counters and truth-table register stay in evolved_circuit_tester.

Test Plan:
- Defaults, cut_out tied 1, res_ready=1, pulse start → 32 results, each res_ones=16 and res_stable=1; truth_table=32'hFFFFFFFF; done rises exactly 672 cycles after the start edge; busy falls on the same edge.
- Behavioural CUT out=cut_in[2] → every res_stable=1; truth_table=32'hF0F0F0F0; res_vector runs 0..31 in order.
- CUT output toggling every clk → res_ones=8 and res_stable=0 for every vector; truth_table=0 (tie resolves to 0).
- Hold res_ready=0 for 10 cycles when res_vector=5 → res_valid, res_vector=5, res_ones and cut_in=5 all held unchanged; sweep resumes with cut_in=6 on the accepting edge.
- SETTLE_CYCLES=3, CUT out=cut_in[0] → truth_table=32'hAAAAAAAA, all res_stable=1 (synchronizer latency covered).
- Pulse start mid-sweep → ignored. Assert rst_n=0 at vector 12 → cut_in=0, busy=0, res_valid=0, truth_table=0 with no clock edge needed. A subsequent start restarts at res_vector=0.

Source files
------------

// File: rtl/evolved_tester_pkg.sv
// Shared types and helpers for the evolved-circuit tester: FSM state encoding
// and the width calculation for the per-vector ones counter.
package evolved_tester_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    REPORT
  } state_t;

  // Bits needed to hold a count from 0 up to and including samples.
  function automatic int ones_width(input int samples);
    return $clog2(samples + 1);
  endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous CUT output into the clk domain.
module bit_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/evolved_circuit_tester.sv
// Sweeps every input vector through a combinational CUT, samples its output
// after a settle window and streams per-vector statistics plus a truth table.
module evolved_circuit_tester
  import evolved_tester_pkg::*;
#(
  parameter  int IN_WIDTH      = 5,
  parameter  int SETTLE_CYCLES = 4,
  parameter  int SAMPLES       = 16,
  localparam int ONES_W        = ones_width(SAMPLES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [IN_WIDTH-1:0]    cut_in,
  input  logic                   cut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IN_WIDTH-1:0]    res_vector,
  output logic [ONES_W-1:0]      res_ones,
  output logic                   res_stable,
  output logic [2**IN_WIDTH-1:0] truth_table
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int SMP_W = $clog2(SAMPLES + 1);

  localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SMP_W-1:0]    SAMPLE_LAST = SMP_W'(SAMPLES - 1);
  localparam logic [IN_WIDTH-1:0] LAST_VEC    = IN_WIDTH'(2**IN_WIDTH - 1);
  localparam logic [ONES_W-1:0]   ALL_ONES    = ONES_W'(SAMPLES);
  localparam logic [ONES_W-1:0]   HALF        = ONES_W'(SAMPLES / 2);

  state_t             state, state_next;
  logic [SET_W-1:0]   settle_cnt;
  logic [SMP_W-1:0]   sample_cnt;
  logic [ONES_W-1:0]  ones;
  logic [ONES_W-1:0]  ones_final;
  logic               cut_sync;
  logic               load_start, settle_done, sample_done, accept, last_vec;

  bit_sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cut_out),
    .q     (cut_sync)
  );

  // cut_in doubles as the current vector index; it only changes on an accept.
  assign last_vec   = (cut_in == LAST_VEC);
  assign ones_final = ones + ONES_W'(cut_sync);
  assign res_valid  = (state == REPORT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    load_start  = 1'b0;
    settle_done = 1'b0;
    sample_done = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_done = 1'b1;
          state_next  = SAMPLE;
        end
      end
      SAMPLE: begin
        if (sample_cnt == SAMPLE_LAST) begin
          sample_done = 1'b1;
          state_next  = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          accept     = 1'b1;
          state_next = last_vec ? IDLE : SETTLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the truth table is a plain flop vector, not a RAM, so it takes the
  // async reset like any other register and clears with no clock running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cut_in      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      res_vector  <= '0;
      res_ones    <= '0;
      res_stable  <= 1'b0;
      truth_table <= '0;
      settle_cnt  <= '0;
      sample_cnt  <= '0;
      ones        <= '0;
    end else begin
      if (load_start) begin
        cut_in      <= '0;
        truth_table <= '0;
        done        <= 1'b0;
        busy        <= 1'b1;
        settle_cnt  <= '0;
      end

      if (state == SETTLE) settle_cnt <= settle_cnt + 1'b1;

      if (settle_done) begin
        ones       <= '0;
        sample_cnt <= '0;
      end

      if (state == SAMPLE) begin
        ones       <= ones_final;
        sample_cnt <= sample_cnt + 1'b1;
      end

      if (sample_done) begin
        res_vector <= cut_in;
        res_ones   <= ones_final;
        res_stable <= (ones_final == '0) || (ones_final == ALL_ONES);
      end

      // A tie (exactly half ones) resolves to 0.
      if (accept) begin
        truth_table[cut_in] <= (res_ones > HALF);
        if (last_vec) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cut_in     <= cut_in + 1'b1;
          settle_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_evolved_circuit_tester.sv
// Scoreboard bench for evolved_circuit_tester: stimulus pushes expected
// per-vector results, negedge monitors pop and compare on each handshake.
module tb_evolved_circuit_tester;

  localparam int NV    = 32;
  localparam int LIMIT = 2000;

  typedef struct packed {
    logic [4:0] vec;
    logic [4:0] ones;
    logic       stable;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        res_ready = 1'b1;
  logic        cut_out;
  logic [4:0]  cut_in, res_vector, res_ones;
  logic        busy, done, res_valid, res_stable;
  logic [31:0] truth_table;

  logic        b_start = 1'b0;
  logic        b_ready = 1'b1;
  logic        b_cut_out;
  logic [4:0]  b_cut_in, b_vector, b_ones;
  logic        b_busy, b_done, b_valid, b_stable;
  logic [31:0] b_truth;

  int   cut_mode = 0;
  logic tog = 1'b0;
  exp_t q[$];
  exp_t q3[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  always @* begin
    case (cut_mode)
      0:       cut_out = 1'b1;
      1:       cut_out = cut_in[2];
      2:       cut_out = tog;
      default: cut_out = 1'b0;
    endcase
  end
  assign b_cut_out = b_cut_in[0];

  evolved_circuit_tester dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cut_in(cut_in), .cut_out(cut_out),
    .busy(busy), .done(done), .res_valid(res_valid), .res_ready(res_ready),
    .res_vector(res_vector), .res_ones(res_ones), .res_stable(res_stable),
    .truth_table(truth_table)
  );

  evolved_circuit_tester #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .cut_in(b_cut_in), .cut_out(b_cut_out),
    .busy(b_busy), .done(b_done), .res_valid(b_valid), .res_ready(b_ready),
    .res_vector(b_vector), .res_ones(b_ones), .res_stable(b_stable),
    .truth_table(b_truth)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid && res_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got vector %0d expected none", res_vector);
      end else begin
        e = q.pop_front();
        check("res_vector", res_vector, e.vec);
        check("res_ones", res_ones, e.ones);
        check("res_stable", res_stable, e.stable);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b_valid && b_ready) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result3: got vector %0d expected none", b_vector);
      end else begin
        e = q3.pop_front();
        check("res_vector3", b_vector, e.vec);
        check("res_ones3", b_ones, e.ones);
        check("res_stable3", b_stable, e.stable);
      end
    end
  end

  // mode 0: constant 1, 1: cut_in[2], 2: toggling (tie), 3: cut_in[0]
  task automatic push_sweep(input int mode, input bit to_q3);
    exp_t e;
    logic [4:0] v;
    for (int i = 0; i < NV; i++) begin
      v = 5'(i);
      case (mode)
        0:       e.ones = 5'd16;
        1:       e.ones = v[2] ? 5'd16 : 5'd0;
        2:       e.ones = 5'd8;
        default: e.ones = v[0] ? 5'd16 : 5'd0;
      endcase
      e.vec    = v;
      e.stable = (e.ones == 5'd0) || (e.ones == 5'd16);
      if (to_q3) q3.push_back(e);
      else       q.push_back(e);
    end
  endtask

  // Returns #1 after the edge that accepts start.
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < LIMIT) begin
      @(posedge clk); #1 n++;
    end
    check("sweep_done", done, 1'b1);
  endtask

  task automatic wait_vec(input logic [4:0] v);
    int n = 0;
    while (cut_in != v && n < LIMIT) begin
      @(posedge clk); #1 n++;
    end
    check("reach_vector", cut_in, v);
  endtask

  initial begin
    int n;
    #2;
    check("rst_cut_in", cut_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", res_valid, 0);
    check("rst_res_vector", res_vector, 0);
    check("rst_res_ones", res_ones, 0);
    check("rst_res_stable", res_stable, 0);
    check("rst_truth", truth_table, 0);
    #20 rst_n = 1'b1;

    // Constant-1 CUT: full sweep timing.
    cut_mode = 0;
    push_sweep(0, 1'b0);
    pulse_start();
    check("busy_after_start", busy, 1);
    wait_done(n);
    check("done_latency", n, 672);
    check("busy_falls", busy, 0);
    check("truth_const1", truth_table, 32'hFFFFFFFF);
    check("queue_drained1", q.size(), 0);

    // CUT = cut_in[2].
    cut_mode = 1;
    push_sweep(1, 1'b0);
    pulse_start();
    check("done_cleared", done, 0);
    wait_done(n);
    check("truth_bit2", truth_table, 32'hF0F0F0F0);
    check("queue_drained2", q.size(), 0);

    // Toggling CUT: 8 of 16, tie resolves to 0.
    cut_mode = 2;
    push_sweep(2, 1'b0);
    pulse_start();
    wait_done(n);
    check("truth_toggle", truth_table, 32'h0);
    check("queue_drained3", q.size(), 0);

    // Back-pressure on vector 5.
    cut_mode = 1;
    push_sweep(1, 1'b0);
    pulse_start();
    wait_vec(5'd5);
    res_ready = 1'b0;
    n = 0;
    while (!res_valid && n < LIMIT) begin
      @(posedge clk); #1 n++;
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("hold_valid", res_valid, 1);
      check("hold_vector", res_vector, 5);
      check("hold_ones", res_ones, 16);
      check("hold_cut_in", cut_in, 5);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("resume_cut_in", cut_in, 6);
    check("resume_valid", res_valid, 0);
    wait_done(n);
    check("truth_hold", truth_table, 32'hF0F0F0F0);
    check("queue_drained4", q.size(), 0);

    // Mid-sweep start ignored, then async reset at vector 12.
    push_sweep(1, 1'b0);
    pulse_start();
    wait_vec(5'd3);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_vec(5'd12);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cut_in", cut_in, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_truth", truth_table, 0);
    check("mid_rst_done", done, 0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    push_sweep(1, 1'b0);
    pulse_start();
    wait_done(n);
    check("truth_restart", truth_table, 32'hF0F0F0F0);
    check("queue_drained5", q.size(), 0);

    // SETTLE_CYCLES=3 instance, CUT = cut_in[0].
    push_sweep(3, 1'b1);
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    n = 0;
    while (!b_done && n < LIMIT) begin
      @(posedge clk); #1 n++;
    end
    check("done3", b_done, 1);
    check("done3_latency", n, 640);
    check("truth_settle3", b_truth, 32'hAAAAAAAA);
    check("queue_drained6", q3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
